// File: rtl/simmem_release_scheduler.sv
// Round-robin release scheduler: picks one releasable delay-bank entry at a time
// and offers its index downstream on a valid/ready handshake.
module simmem_release_scheduler #(
   parameter int unsigned NumEntries = 16,
   parameter int unsigned IdxWidth   = $clog2(NumEntries),
   parameter int unsigned CntWidth   = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NumEntries-1:0] release_en_i,
   input  logic                  enable_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [IdxWidth-1:0]   out_idx_o,
   output logic [NumEntries-1:0] address_released_onehot_o,
   output logic [CntWidth-1:0]   grant_cnt_o,
   input  logic                  clear_cnt_i
);

   typedef enum logic {
      IDLE,
      OFFER
   } state_e;

   state_e                state_q;
   logic [IdxWidth-1:0]   rr_ptr_q;

   logic                  hs;
   logic [NumEntries-1:0] cur_onehot;
   logic [NumEntries-1:0] eligible;
   logic [IdxWidth-1:0]   next_ptr;
   logic [IdxWidth-1:0]   search_base;
   logic [IdxWidth-1:0]   pos;
   logic [IdxWidth-1:0]   sel_idx;
   logic                  sel_found;

   assign hs = out_valid_o & out_ready_i;

   always_comb begin
      cur_onehot            = '0;
      cur_onehot[out_idx_o] = 1'b1;
   end

   // The entry being released still shows up in release_en_i this cycle.
   assign eligible = release_en_i & ~(hs ? cur_onehot : '0);

   assign next_ptr = (out_idx_o == IdxWidth'(NumEntries - 1)) ? '0
                                                              : out_idx_o + IdxWidth'(1);

   // After a handshake the search already starts past the entry being released.
   assign search_base = hs ? next_ptr : rr_ptr_q;

   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      pos       = '0;
      for (int unsigned i = 0; i < NumEntries; i++) begin
         pos = IdxWidth'((32'(search_base) + i) % NumEntries);
         if (!sel_found && eligible[pos]) begin
            sel_found = 1'b1;
            sel_idx   = pos;
         end
      end
   end

   assign address_released_onehot_o = hs ? cur_onehot : '0;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         out_valid_o <= 1'b0;
         out_idx_o   <= '0;
         rr_ptr_q    <= '0;
         grant_cnt_o <= '0;
      end else begin
         if (clear_cnt_i) begin
            grant_cnt_o <= '0;
         end else if (hs && (grant_cnt_o != '1)) begin
            grant_cnt_o <= grant_cnt_o + CntWidth'(1);
         end

         case (state_q)
            IDLE: begin
               if (enable_i && sel_found) begin
                  out_idx_o   <= sel_idx;
                  out_valid_o <= 1'b1;
                  state_q     <= OFFER;
               end
            end
            OFFER: begin
               if (hs) begin
                  rr_ptr_q <= next_ptr;
                  if (enable_i && sel_found) begin
                     out_idx_o <= sel_idx;
                  end else begin
                     out_valid_o <= 1'b0;
                     state_q     <= IDLE;
                  end
               end
            end
            default: begin
               out_valid_o <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Directed bench for simmem_release_scheduler: a per-cycle vector table plus
// hand-written back-to-back and counter-saturation sequences.
module tb_simmem_release_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, en, rdy, clr;
   logic [15:0] rel;
   logic        valid;
   logic [3:0]  idx;
   logic [15:0] oh;
   logic [15:0] cnt;

   logic        s_rst_n, s_en, s_rdy, s_clr;
   logic [15:0] s_rel;
   logic        s_valid;
   logic [3:0]  s_idx;
   logic [15:0] s_oh;
   logic [2:0]  s_cnt;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   simmem_release_scheduler dut (
      .clk_i                    (clk),
      .rst_ni                   (rst_n),
      .release_en_i             (rel),
      .enable_i                 (en),
      .out_valid_o              (valid),
      .out_ready_i              (rdy),
      .out_idx_o                (idx),
      .address_released_onehot_o(oh),
      .grant_cnt_o              (cnt),
      .clear_cnt_i              (clr)
   );

   // Narrow counter instance so saturation is reachable in a few cycles.
   simmem_release_scheduler #(
      .NumEntries(16),
      .CntWidth  (3)
   ) dut_sat (
      .clk_i                    (clk),
      .rst_ni                   (s_rst_n),
      .release_en_i             (s_rel),
      .enable_i                 (s_en),
      .out_valid_o              (s_valid),
      .out_ready_i              (s_rdy),
      .out_idx_o                (s_idx),
      .address_released_onehot_o(s_oh),
      .grant_cnt_o              (s_cnt),
      .clear_cnt_i              (s_clr)
   );

   a_no_drop: assert property (@(posedge clk) disable iff (!rst_n)
      (valid && !rdy) |-> rel[idx])
      else $error("FAIL illegal_drop: release_en[%0d] dropped during offer", idx);

   a_rdy_known: assert property (@(posedge clk) disable iff (!rst_n)
      valid |-> !$isunknown(rdy))
      else $error("FAIL ready_x: out_ready_i unknown during offer");

   typedef struct {
      logic        rst_n;
      logic [15:0] rel;
      logic        en;
      logic        rdy;
      logic        clr;
      logic        chk_idx;
      logic        exp_v;
      logic [3:0]  exp_idx;
      logic [15:0] exp_oh;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic [15:0] re, input logic e,
                               input logic rd, input logic c, input logic ci,
                               input logic v, input logic [3:0] ix,
                               input logic [15:0] o, input logic [15:0] n);
      vec_t t;
      t.rst_n = r;  t.rel = re;   t.en = e;      t.rdy = rd;   t.clr = c;
      t.chk_idx = ci; t.exp_v = v; t.exp_idx = ix; t.exp_oh = o; t.exp_cnt = n;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   initial begin
      logic [15:0] bit_i;

      // Row = inputs for one cycle, then expected outputs seen during that cycle.
      //                 rst rel     en rdy clr chk v idx oh       cnt
      vecs.push_back(mk(1, 16'h0000, 1, 1, 0,  1, 0, 0,  16'h0000, 0)); // reset state
      vecs.push_back(mk(1, 16'h0000, 1, 1, 0,  0, 0, 0,  16'h0000, 0));
      vecs.push_back(mk(1, 16'h0001, 1, 1, 0,  0, 0, 0,  16'h0000, 0)); // bit 0 rises
      vecs.push_back(mk(1, 16'h0001, 1, 1, 0,  1, 1, 0,  16'h0001, 0));
      vecs.push_back(mk(1, 16'h0000, 1, 1, 0,  0, 0, 0,  16'h0000, 1));
      vecs.push_back(mk(0, 16'h0000, 1, 1, 0,  0, 0, 0,  16'h0000, 1)); // reset rr_ptr
      vecs.push_back(mk(1, 16'h8081, 1, 1, 0,  0, 0, 0,  16'h0000, 0));
      vecs.push_back(mk(1, 16'h8081, 1, 1, 0,  1, 1, 0,  16'h0001, 0));
      vecs.push_back(mk(1, 16'h8080, 1, 1, 0,  1, 1, 7,  16'h0080, 1));
      vecs.push_back(mk(1, 16'h8000, 1, 1, 0,  1, 1, 15, 16'h8000, 2));
      vecs.push_back(mk(1, 16'h0000, 1, 1, 0,  0, 0, 0,  16'h0000, 3));
      vecs.push_back(mk(1, 16'h4000, 1, 0, 0,  0, 0, 0,  16'h0000, 3)); // move rr_ptr to 15
      vecs.push_back(mk(1, 16'h4000, 1, 1, 0,  1, 1, 14, 16'h4000, 3));
      vecs.push_back(mk(1, 16'h8001, 1, 1, 0,  0, 0, 0,  16'h0000, 4));
      vecs.push_back(mk(1, 16'h8001, 1, 1, 0,  1, 1, 15, 16'h8000, 4));
      vecs.push_back(mk(1, 16'h0001, 1, 1, 0,  1, 1, 0,  16'h0001, 5)); // wrapped
      vecs.push_back(mk(1, 16'h0000, 1, 1, 0,  0, 0, 0,  16'h0000, 6));
      vecs.push_back(mk(0, 16'h0000, 1, 1, 0,  0, 0, 0,  16'h0000, 6));
      vecs.push_back(mk(1, 16'h0003, 1, 1, 0,  0, 0, 0,  16'h0000, 0));
      vecs.push_back(mk(1, 16'h0003, 1, 1, 0,  1, 1, 0,  16'h0001, 0));
      vecs.push_back(mk(1, 16'h0003, 1, 1, 0,  1, 1, 1,  16'h0002, 1)); // entry 0 re-raised
      vecs.push_back(mk(1, 16'h0001, 1, 1, 0,  1, 1, 0,  16'h0001, 2));
      vecs.push_back(mk(1, 16'h0000, 1, 1, 0,  0, 0, 0,  16'h0000, 3));
      vecs.push_back(mk(1, 16'h0008, 1, 0, 0,  0, 0, 0,  16'h0000, 3)); // stall on idx 3
      vecs.push_back(mk(1, 16'h0008, 0, 0, 0,  1, 1, 3,  16'h0000, 3));
      for (int k = 0; k < 4; k++)
         vecs.push_back(mk(1, 16'h0018, 0, 0, 0,  1, 1, 3,  16'h0000, 3));
      vecs.push_back(mk(1, 16'h0018, 0, 1, 0,  1, 1, 3,  16'h0008, 3));
      vecs.push_back(mk(1, 16'h0010, 0, 1, 0,  0, 0, 0,  16'h0000, 4)); // disabled: no pick
      vecs.push_back(mk(1, 16'h0010, 0, 1, 0,  0, 0, 0,  16'h0000, 4));
      vecs.push_back(mk(1, 16'h0010, 1, 0, 0,  0, 0, 0,  16'h0000, 4));
      vecs.push_back(mk(1, 16'h0010, 1, 0, 0,  1, 1, 4,  16'h0000, 4));
      vecs.push_back(mk(0, 16'h0010, 1, 0, 0,  1, 1, 4,  16'h0000, 4)); // reset mid-offer
      vecs.push_back(mk(1, 16'h0010, 0, 1, 0,  1, 0, 0,  16'h0000, 0));
      vecs.push_back(mk(1, 16'h0010, 1, 1, 0,  0, 0, 0,  16'h0000, 0));
      vecs.push_back(mk(1, 16'h0010, 1, 1, 0,  1, 1, 4,  16'h0010, 0));
      vecs.push_back(mk(1, 16'h0001, 1, 1, 0,  0, 0, 0,  16'h0000, 1));
      vecs.push_back(mk(1, 16'h0001, 1, 1, 1,  1, 1, 0,  16'h0001, 1)); // clear with hs
      vecs.push_back(mk(1, 16'h0000, 1, 1, 0,  0, 0, 0,  16'h0000, 0));

      rst_n = 1'b0; rel = '0; en = 1'b0; rdy = 1'b0; clr = 1'b0;
      s_rst_n = 1'b0; s_rel = '0; s_en = 1'b0; s_rdy = 1'b0; s_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         rst_n = vecs[i].rst_n; rel = vecs[i].rel; en = vecs[i].en;
         rdy = vecs[i].rdy; clr = vecs[i].clr;
         @(negedge clk);
         check($sformatf("row%0d valid", i), 32'(valid), 32'(vecs[i].exp_v));
         if (vecs[i].chk_idx)
            check($sformatf("row%0d idx", i), 32'(idx), 32'(vecs[i].exp_idx));
         check($sformatf("row%0d onehot", i), 32'(oh), 32'(vecs[i].exp_oh));
         check($sformatf("row%0d cnt", i), 32'(cnt), 32'(vecs[i].exp_cnt));
         @(posedge clk);
         #1;
      end

      // All 16 entries pending, bank clears each released bit: 0..15 back to back.
      rst_n = 1'b0; rel = 16'hFFFF; en = 1'b1; rdy = 1'b1; clr = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) begin
         bit_i = 16'h0001 << i;
         @(negedge clk);
         check($sformatf("b2b%0d valid", i), 32'(valid), 32'd1);
         check($sformatf("b2b%0d idx", i), 32'(idx), 32'(i));
         check($sformatf("b2b%0d onehot", i), 32'(oh), 32'(bit_i));
         @(posedge clk);
         #1;
         rel[i] = 1'b0;
      end
      @(negedge clk);
      check("b2b_end valid", 32'(valid), 32'd0);
      check("b2b_end cnt", 32'(cnt), 32'd16);

      // 3-bit counter: one grant per cycle from the second edge on.
      s_rel = 16'hFFFF; s_en = 1'b1; s_rdy = 1'b1; s_rst_n = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      check("sat reach_max", 32'(s_cnt), 32'd7);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("sat hold_max", 32'(s_cnt), 32'd7);
      check("sat hs_active", 32'(s_valid), 32'd1);
      s_clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("sat clear_wins", 32'(s_cnt), 32'd0);
      s_clr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("sat count_after_clear", 32'(s_cnt), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
